temporizador_bcd_param: RTL and testbench

//  Parametrised BCD countdown/count-up timer with built-in tick prescaler, replacing the fixed 3-digit

---
 rtl/temporizador_bcd_param_pkg.sv | 36 +++
 rtl/temporizador_bcd_param_bcd_digit_step.sv | 37 +++
 rtl/temporizador_bcd_param.sv | 187 ++++++++++++++++++
 tb/tb_temporizador_bcd_param.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temporizador_bcd_param_pkg.sv
// Shared definitions for the BCD timer: FSM state encoding, count direction and
// per-digit BCD limits for the MM..M:S:s time layout.
package temporizador_bcd_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    localparam logic [3:0] BCD_MAX_SEC  = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_MIN  = 4'd9;

    // Nibble 0 is seconds, nibble 1 tens-of-seconds, every higher nibble a minute digit.
    function automatic logic [3:0] digit_max(input int idx);
        logic [3:0] v;
        if (idx == 0) begin
            v = BCD_MAX_SEC;
        end else if (idx == 1) begin
            v = BCD_MAX_TENS;
        end else begin
            v = BCD_MAX_MIN;
        end
        return v;
    endfunction

    function automatic logic digit_ok(input logic [3:0] d, input int idx);
        return (d <= digit_max(idx));
    endfunction

endpackage

// File: rtl/temporizador_bcd_param_bcd_digit_step.sv
// One BCD digit of the ripple counter: steps up or down by one when enabled and
// reports a carry (up) or borrow (down) to the next more significant digit.
module bcd_digit_step
    import temporizador_bcd_param_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_SEC
) (
    input  logic [3:0] i_digit,
    input  logic       i_en,
    input  logic       i_dir,
    output logic [3:0] o_next,
    output logic       o_carry
);

    always_comb begin
        o_next  = i_digit;
        o_carry = 1'b0;
        if (i_en) begin
            if (i_dir == MODE_UP) begin
                if (i_digit >= MAX) begin
                    o_next  = 4'd0;
                    o_carry = 1'b1;
                end else begin
                    o_next = i_digit + 4'd1;
                end
            end else begin
                if (i_digit == 4'd0) begin
                    o_next  = MAX;
                    o_carry = 1'b1;
                end else begin
                    o_next = i_digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/temporizador_bcd_param.sv
// Parametrised BCD countdown/count-up timer with internal tick prescaler,
// explicit load/start, pause, invalid-BCD rejection and a timed alarm.
module temporizador_bcd_param
    import temporizador_bcd_param_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int N_MIN       = 2,
    parameter int ALARM_TICKS = 10,
    localparam int W          = 4 * (N_MIN + 2)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] tiempo_establecido,
    input  logic         mode,
    input  logic         start,
    input  logic         pause,
    output logic [W-1:0] tiempo_actual,
    output logic         running,
    output logic         alarma,
    output logic         tick_out,
    output logic         load_err
);

    localparam int ND  = N_MIN + 2;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [AW-1:0]   r_alarm_cnt;
    logic [W-1:0]    r_time;
    logic [W-1:0]    r_target;
    logic            r_mode;
    logic            r_running;
    logic            r_alarma;
    logic            r_tick;
    logic            r_load_err;

    logic [ND:0]     w_carry;
    logic [W-1:0]    w_next;
    logic [W-1:0]    w_end_val;
    logic            w_tick;
    logic            w_load_ok;
    logic            w_at_end;
    logic            w_next_at_end;

    // Ripple chain: the least significant digit always steps, each higher
    // digit steps only when the one below it wraps.
    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < ND; gi++) begin : g_digit
        bcd_digit_step #(
            .MAX (digit_max(gi))
        ) u_digit (
            .i_digit (r_time[4*gi +: 4]),
            .i_en    (w_carry[gi]),
            .i_dir   (r_mode),
            .o_next  (w_next[4*gi +: 4]),
            .o_carry (w_carry[gi+1])
        );
    end

    always_comb begin
        w_load_ok = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (!digit_ok(tiempo_establecido[4*i +: 4], i)) begin
                w_load_ok = 1'b0;
            end
        end
    end

    assign w_end_val     = (r_mode == MODE_UP) ? r_target : '0;
    assign w_tick        = (r_presc == PRESC_LAST);
    assign w_at_end      = (r_time == w_end_val);
    assign w_next_at_end = (w_next == w_end_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_alarm_cnt <= '0;
            r_time      <= '0;
            r_target    <= '0;
            r_mode      <= MODE_DOWN;
            r_running   <= 1'b0;
            r_alarma    <= 1'b0;
            r_tick      <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_tick     <= 1'b0;
            r_load_err <= 1'b0;
            if (load && w_load_ok) begin
                // A valid load aborts whatever was in progress.
                r_state     <= ST_IDLE;
                r_target    <= tiempo_establecido;
                r_mode      <= mode;
                r_time      <= (mode == MODE_UP) ? '0 : tiempo_establecido;
                r_presc     <= '0;
                r_alarm_cnt <= '0;
                r_running   <= 1'b0;
                r_alarma    <= 1'b0;
            end else begin
                // A rejected load only reports the error; normal operation continues.
                r_load_err <= load;
                unique case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_presc     <= '0;
                            r_alarm_cnt <= '0;
                            if (w_at_end) begin
                                r_state  <= ST_DONE;
                                r_alarma <= 1'b1;
                            end else begin
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            r_state   <= ST_PAUSED;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (w_carry[ND]) begin
                                // Would wrap past the top digit; stop rather than roll over.
                                r_state     <= ST_DONE;
                                r_running   <= 1'b0;
                                r_alarma    <= 1'b1;
                                r_alarm_cnt <= '0;
                            end else begin
                                r_time <= w_next;
                                r_tick <= 1'b1;
                                if (w_next_at_end) begin
                                    r_state     <= ST_DONE;
                                    r_running   <= 1'b0;
                                    r_alarma    <= 1'b1;
                                    r_alarm_cnt <= '0;
                                end
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (start) begin
                            r_state  <= ST_IDLE;
                            r_alarma <= 1'b0;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (r_alarm_cnt == ALARM_LAST) begin
                                r_state  <= ST_IDLE;
                                r_alarma <= 1'b0;
                            end else begin
                                r_alarm_cnt <= r_alarm_cnt + 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tiempo_actual = r_time;
    assign running       = r_running;
    assign alarma        = r_alarma;
    assign tick_out      = r_tick;
    assign load_err      = r_load_err;

endmodule

// File: tb/tb_temporizador_bcd_param.sv
// Bench for temporizador_bcd_param: directed scenarios plus random traffic, all
// compared each cycle against a seconds-based reference model.
module tb_temporizador_bcd_param;

    localparam int CLK_HZ      = 10;
    localparam int TICK_HZ     = 1;
    localparam int N_MIN       = 2;
    localparam int ALARM_TICKS = 3;
    localparam int W           = 16;
    localparam int DIV         = CLK_HZ / TICK_HZ;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] tiempo_establecido;
    logic         mode;
    logic         start;
    logic         pause;
    logic [W-1:0] tiempo_actual;
    logic         running;
    logic         alarma;
    logic         tick_out;
    logic         load_err;

    always #5 clk = ~clk;

    temporizador_bcd_param #(
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .N_MIN       (N_MIN),
        .ALARM_TICKS (ALARM_TICKS)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .load               (load),
        .tiempo_establecido (tiempo_establecido),
        .mode               (mode),
        .start              (start),
        .pause              (pause),
        .tiempo_actual      (tiempo_actual),
        .running            (running),
        .alarma             (alarma),
        .tick_out           (tick_out),
        .load_err           (load_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: time held as plain seconds, phase as clocks since last tick.
    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} m_st_t;
    m_st_t m_st = M_IDLE;
    int    m_secs = 0;
    int    m_target = 0;
    int    m_phase = 0;
    int    m_alarm_left = 0;
    bit    m_up = 0;
    bit    m_alarm = 0;
    bit    m_tick = 0;
    bit    m_err = 0;

    function automatic int to_secs(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v);
        return (v[15:12] <= 9) && (v[11:8] <= 9) && (v[7:4] <= 5) && (v[3:0] <= 9);
    endfunction

    task automatic enter_done();
        m_st         = M_DONE;
        m_alarm      = 1;
        m_alarm_left = ALARM_TICKS;
    endtask

    task automatic model_edge();
        int endv;
        m_tick = 0;
        m_err  = 0;
        if (reset) begin
            m_st = M_IDLE; m_secs = 0; m_target = 0; m_phase = 0;
            m_up = 0; m_alarm = 0; m_alarm_left = 0;
        end else if (load && bcd_ok(tiempo_establecido)) begin
            m_st     = M_IDLE;
            m_target = to_secs(tiempo_establecido);
            m_up     = mode;
            m_secs   = mode ? 0 : m_target;
            m_phase  = 0;
            m_alarm  = 0;
        end else begin
            m_err = load;
            endv  = m_up ? m_target : 0;
            case (m_st)
                M_IDLE: if (start) begin
                    m_phase = 0;
                    if (m_secs == endv) enter_done();
                    else m_st = M_RUN;
                end
                M_RUN: begin
                    if (pause) m_st = M_PAUSED;
                    else if (m_phase == DIV - 1) begin
                        m_phase = 0;
                        m_secs  = m_up ? m_secs + 1 : m_secs - 1;
                        m_tick  = 1;
                        if (m_secs == endv) enter_done();
                    end else m_phase++;
                end
                M_PAUSED: if (!pause) m_st = M_RUN;
                M_DONE: begin
                    if (start) begin
                        m_st = M_IDLE; m_alarm = 0;
                    end else if (m_phase == DIV - 1) begin
                        m_phase = 0;
                        m_alarm_left--;
                        if (m_alarm_left == 0) begin
                            m_st = M_IDLE; m_alarm = 0;
                        end
                    end else m_phase++;
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("tiempo_actual", tiempo_actual, to_bcd(m_secs));
        check_eq("running", running, (m_st == M_RUN));
        check_eq("alarma", alarma, m_alarm);
        check_eq("tick_out", tick_out, m_tick);
        check_eq("load_err", load_err, m_err);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic md);
        tiempo_establecido = v;
        mode = md;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [W-1:0] exp_q[$];

    initial begin
        int n_ticks;
        int n_alarm;
        int n_wait;
        logic [3:0] d1, d0;

        reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; mode = 1'b0;
        tiempo_establecido = '0;
        @(negedge clk);
        run(2);
        check_eq("reset_tiempo", tiempo_actual, 16'h0000);
        check_eq("reset_running", running, 1'b0);
        check_eq("reset_alarma", alarma, 1'b0);
        reset = 1'b0;
        run(3);

        // Countdown from 3 seconds, then a 3-tick alarm.
        do_load(16'h0003, 1'b0);
        check_eq("t1_loaded", tiempo_actual, 16'h0003);
        exp_q = {16'h0002, 16'h0001, 16'h0000};
        n_ticks = 0; n_alarm = 0;
        do_start();
        for (int i = 0; i < 70; i++) begin
            step();
            if (tick_out) begin
                n_ticks++;
                if (exp_q.size() > 0) check_eq("t1_seq", tiempo_actual, exp_q.pop_front());
            end
            if (alarma) n_alarm++;
        end
        check_eq("t1_ticks", n_ticks, 3);
        check_eq("t1_alarm_len", n_alarm, 30);
        check_eq("t1_idle_running", running, 1'b0);

        // Borrow across every digit.
        do_load(16'h1000, 1'b0);
        do_start();
        run(10);
        check_eq("t2_borrow", tiempo_actual, 16'h0959);
        check_eq("t2_running", running, 1'b1);

        // Count up to one minute.
        do_load(16'h0100, 1'b1);
        check_eq("t3_up_start", tiempo_actual, 16'h0000);
        do_start();
        run(590);
        check_eq("t3_59", tiempo_actual, 16'h0059);
        check_eq("t3_no_alarm", alarma, 1'b0);
        run(10);
        check_eq("t3_target", tiempo_actual, 16'h0100);
        check_eq("t3_alarm", alarma, 1'b1);

        // Pause with the prescaler at 6 keeps the fraction of the second.
        do_load(16'h0005, 1'b0);
        do_start();
        run(6);
        pause = 1'b1;
        run(50);
        check_eq("t4_frozen", tiempo_actual, 16'h0005);
        check_eq("t4_paused_running", running, 1'b0);
        pause = 1'b0;
        step();
        n_wait = 0;
        while (n_wait < 20) begin
            step();
            n_wait++;
            if (tick_out) break;
        end
        check_eq("t4_resume_latency", n_wait, 4);
        check_eq("t4_value", tiempo_actual, 16'h0004);

        // Invalid loads are rejected; zero countdown finishes immediately.
        do_load(16'h0012, 1'b0);
        do_load(16'h0060, 1'b0);
        check_eq("t5_err", load_err, 1'b1);
        check_eq("t5_kept", tiempo_actual, 16'h0012);
        do_load(16'hA000, 1'b1);
        check_eq("t5_err_min", load_err, 1'b1);
        step();
        check_eq("t5_err_clear", load_err, 1'b0);
        do_load(16'h0000, 1'b0);
        do_start();
        check_eq("t5_done_alarm", alarma, 1'b1);
        do_start();
        check_eq("t5_ack", alarma, 1'b0);
        run(25);
        check_eq("t5_stays_idle", alarma, 1'b0);

        // Reset mid-run and load mid-alarm.
        do_load(16'h0030, 1'b0);
        do_start();
        run(15);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_rst_tiempo", tiempo_actual, 16'h0000);
        check_eq("t6_rst_running", running, 1'b0);
        do_load(16'h0001, 1'b0);
        do_start();
        run(10);
        check_eq("t6_in_done", alarma, 1'b1);
        do_load(16'h0042, 1'b0);
        check_eq("t6_load_alarm", alarma, 1'b0);
        check_eq("t6_load_tiempo", tiempo_actual, 16'h0042);
        check_eq("t6_load_running", running, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            load  = (r < 3);
            start = (r >= 3 && r < 8);
            reset = (r == 99) && ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) pause = ~pause;
            d1 = ($urandom_range(0, 7) == 0) ? 4'd6 : 4'($urandom_range(0, 1));
            d0 = 4'($urandom_range(0, 10));
            tiempo_establecido = {4'd0, 4'($urandom_range(0, 15) == 0), d1, d0};
            mode = 1'($urandom_range(0, 1));
            step();
        end
        load = 1'b0; start = 1'b0; reset = 1'b0; pause = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
